// File: rtl/simd_wakeup_ctrl.sv
// ---------------------------------------------------------------------------
// simd_wakeup_ctrl
// Producer side of the lane mark-ready interface of simd_unit. Each issued tag
// {lane, rs_index} is parked in a shared pending buffer together with an
// operand-availability delay. The delay counts down. Once it reaches zero, the
// owning lane receives a registered one-cycle wakeup pulse carrying the RS
// index.
//
// Ports
//   i_clk               clock, all logic on posedge
//   i_reset             synchronous, active-high reset
//   i_issue_valid       a tag is presented this cycle
//   i_issue_lane        binary lane number of the tag
//   i_issue_rs_index    RS slot index within that lane
//   i_issue_delay       cycles until the operands are ready
//   o_issue_ready       buffer can accept a tag this cycle (state-only)
//   o_mark_ready_valid  per-lane wakeup pulse, registered
//   o_mark_ready_idx    per-lane RS index, lane l at [l*RS_SIZE +: RS_SIZE]
//   o_pending_count     number of occupied buffer entries
//   o_err_overflow      sticky: tag dropped because the buffer was full
//   o_err_bad_lane      sticky: tag dropped because the lane was out of range
// ---------------------------------------------------------------------------
module simd_wakeup_ctrl #(
    parameter int LANES   = 4,
    parameter int RS_SIZE = 4,
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 4,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_issue_valid,
    input  logic [LW-1:0]            i_issue_lane,
    input  logic [RS_SIZE-1:0]       i_issue_rs_index,
    input  logic [DELAY_W-1:0]       i_issue_delay,
    output logic                     o_issue_ready,
    output logic [LANES-1:0]         o_mark_ready_valid,
    output logic [LANES*RS_SIZE-1:0] o_mark_ready_idx,
    output logic [CW-1:0]            o_pending_count,
    output logic                     o_err_overflow,
    output logic                     o_err_bad_lane
);

    localparam int EW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW:0]   C_LANES = (LW+1)'(LANES);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [DEPTH-1:0]   r_valid;
    logic [LW-1:0]      r_lane [DEPTH];
    logic [RS_SIZE-1:0] r_idx  [DEPTH];
    logic [DELAY_W-1:0] r_cnt  [DEPTH];
    logic [CW-1:0]      r_pending;
    logic [LANES-1:0]   r_mr_valid;
    logic [RS_SIZE-1:0] r_mr_idx [LANES];
    logic               r_err_ovf;
    logic               r_err_bad;

    logic               w_lane_ok;
    logic               w_accept;
    logic [EW-1:0]      w_free_idx;
    logic [LANES-1:0]   w_fire;
    logic [EW-1:0]      w_sel [LANES];
    logic [DEPTH-1:0]   w_clear;
    logic [CW-1:0]      w_fire_cnt;

    // Ready is derived from registered occupancy only, so an entry being
    // freed this cycle never opens the door for a same-cycle accept.
    assign o_issue_ready = (r_pending < C_DEPTH);
    assign w_lane_ok     = ({1'b0, i_issue_lane} < C_LANES);
    assign w_accept      = i_issue_valid && w_lane_ok && o_issue_ready;

    // Lowest-numbered free entry: scan downward so the lowest hit wins.
    always_comb begin
        w_free_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!r_valid[e]) begin
                w_free_idx = EW'(e);
            end
        end
    end

    // Per-lane wakeup select: lowest entry index with an expired count.
    always_comb begin
        w_fire     = '0;
        w_clear    = '0;
        w_fire_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sel[l] = '0;
            for (int e = DEPTH - 1; e >= 0; e--) begin
                if (r_valid[e] && (r_lane[e] == LW'(l)) && (r_cnt[e] == '0)) begin
                    w_fire[l] = 1'b1;
                    w_sel[l]  = EW'(e);
                end
            end
            if (w_fire[l]) begin
                w_clear[w_sel[l]] = 1'b1;
                w_fire_cnt        = w_fire_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid    <= '0;
            r_pending  <= '0;
            r_mr_valid <= '0;
            r_err_ovf  <= 1'b0;
            r_err_bad  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_mr_idx[l] <= '0;
            end
            for (int e = 0; e < DEPTH; e++) begin
                r_lane[e] <= '0;
                r_idx[e]  <= '0;
                r_cnt[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_clear[e]) begin
                    r_valid[e] <= 1'b0;
                end else if (r_valid[e] && (r_cnt[e] != '0)) begin
                    r_cnt[e] <= r_cnt[e] - DELAY_W'(1);
                end
            end

            // The target entry is currently free, so it can never collide
            // with the clear/decrement above.
            if (w_accept) begin
                r_valid[w_free_idx] <= 1'b1;
                r_lane[w_free_idx]  <= i_issue_lane;
                r_idx[w_free_idx]   <= i_issue_rs_index;
                r_cnt[w_free_idx]   <= i_issue_delay;
            end

            for (int l = 0; l < LANES; l++) begin
                r_mr_valid[l] <= w_fire[l];
                if (w_fire[l]) begin
                    r_mr_idx[l] <= r_idx[w_sel[l]];
                end
            end

            r_pending <= r_pending + CW'(w_accept) - w_fire_cnt;

            // A bad lane is reported in preference to a full buffer.
            if (i_issue_valid && !w_lane_ok) begin
                r_err_bad <= 1'b1;
            end else if (i_issue_valid && !o_issue_ready) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        o_mark_ready_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            o_mark_ready_idx[l*RS_SIZE +: RS_SIZE] = r_mr_idx[l];
        end
    end

    assign o_mark_ready_valid = r_mr_valid;
    assign o_pending_count    = r_pending;
    assign o_err_overflow     = r_err_ovf;
    assign o_err_bad_lane     = r_err_bad;

endmodule

// File: tb/tb_simd_wakeup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simd_wakeup_ctrl
// Bench for simd_wakeup_ctrl. dut is the default 4-lane build and is tracked
// by a timestamp-based reference model. dut3 is a 3-lane build that shares
// the same stimulus and is used only where an out-of-range lane is needed.
// ---------------------------------------------------------------------------
module tb_simd_wakeup_ctrl;

    localparam int L  = 4;
    localparam int R  = 4;
    localparam int D  = 8;
    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            iv;
    logic [1:0]      il;
    logic [R-1:0]    ir;
    logic [DW-1:0]   id;

    logic            rdy, ovf, bad;
    logic [L-1:0]    mrv;
    logic [L*R-1:0]  mri;
    logic [3:0]      pend;

    logic            rdy3, ovf3, bad3;
    logic [2:0]      mrv3;
    logic [3*R-1:0]  mri3;
    logic [3:0]      pend3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    simd_wakeup_ctrl #(.LANES(L), .RS_SIZE(R), .DEPTH(D), .DELAY_W(DW)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_issue_valid      (iv),
        .i_issue_lane       (il),
        .i_issue_rs_index   (ir),
        .i_issue_delay      (id),
        .o_issue_ready      (rdy),
        .o_mark_ready_valid (mrv),
        .o_mark_ready_idx   (mri),
        .o_pending_count    (pend),
        .o_err_overflow     (ovf),
        .o_err_bad_lane     (bad)
    );

    simd_wakeup_ctrl #(.LANES(3), .RS_SIZE(R), .DEPTH(D), .DELAY_W(DW)) dut3 (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_issue_valid      (iv),
        .i_issue_lane       (il),
        .i_issue_rs_index   (ir),
        .i_issue_delay      (id),
        .o_issue_ready      (rdy3),
        .o_mark_ready_valid (mrv3),
        .o_mark_ready_idx   (mri3),
        .o_pending_count    (pend3),
        .o_err_overflow     (ovf3),
        .o_err_bad_lane     (bad3)
    );

    // Reference model: each pending tag remembers the first cycle in which
    // its operands are available instead of carrying a countdown.
    bit           m_v    [D];
    logic [1:0]   m_lane [D];
    logic [R-1:0] m_idx  [D];
    int           m_at   [D];
    int           m_pend;
    bit           m_ovf;
    bit           m_bad;
    bit [L-1:0]   m_mrv;
    logic [R-1:0] m_mri  [L];

    task automatic model_edge();
        int fire_slot [L];
        int free_slot;
        if (reset) begin
            for (int s = 0; s < D; s++) m_v[s] = 0;
            for (int l = 0; l < L; l++) m_mri[l] = '0;
            m_pend = 0;
            m_ovf  = 0;
            m_bad  = 0;
            m_mrv  = '0;
        end else begin
            for (int l = 0; l < L; l++) begin
                fire_slot[l] = -1;
                for (int s = 0; s < D; s++)
                    if (fire_slot[l] < 0 && m_v[s] && int'(m_lane[s]) == l && cyc >= m_at[s])
                        fire_slot[l] = s;
            end
            if (iv && m_pend >= D) begin
                m_ovf = 1;
            end else if (iv) begin
                free_slot = -1;
                for (int s = 0; s < D; s++)
                    if (free_slot < 0 && !m_v[s]) free_slot = s;
                m_v[free_slot]    = 1;
                m_lane[free_slot] = il;
                m_idx[free_slot]  = ir;
                m_at[free_slot]   = cyc + 1 + int'(id);
                m_pend++;
            end
            for (int l = 0; l < L; l++) begin
                m_mrv[l] = (fire_slot[l] >= 0);
                if (fire_slot[l] >= 0) begin
                    m_mri[l] = m_idx[fire_slot[l]];
                    m_v[fire_slot[l]] = 0;
                    m_pend--;
                end
            end
        end
        cyc++;
    endtask

    function automatic logic [26:0] exp_vec();
        logic [L*R-1:0] f;
        for (int l = 0; l < L; l++) f[l*R +: R] = m_mri[l];
        return {(m_pend < D), m_ovf, m_bad, 4'(m_pend), f, m_mrv};
    endfunction

    function automatic logic [26:0] obs_vec();
        return {rdy, ovf, bad, pend, mri, mrv};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; iv = 0; il = 0; ir = 0; id = 0;
        tick(); tick();
        reset = 0;
        tests++;
        if (obs_vec() !== {1'b1, 2'b00, 4'd0, 16'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), {1'b1, 26'd0});
        end
        tests++;
        if ({rdy3, ovf3, bad3, pend3, mri3, mrv3} !== {1'b1, 21'd0}) begin
            fails++;
            $display("FAIL reset_state_3lane got=%h exp=%h",
                     {rdy3, ovf3, bad3, pend3, mri3, mrv3}, {1'b1, 21'd0});
        end
    endtask

    task automatic test_single();
        iv = 1; il = 2; ir = 1; id = 0;
        tick();
        iv = 0;
        tests++;
        if (pend !== 4'd1 || mrv !== 4'b0000) begin
            fails++;
            $display("FAIL single_accept pend=%0d mrv=%b exp pend=1 mrv=0000", pend, mrv);
        end
        tick();
        tests++;
        if (mrv !== 4'b0100 || mri[8 +: 4] !== 4'd1 || pend !== 4'd0) begin
            fails++;
            $display("FAIL single_pulse mrv=%b idx2=%0d pend=%0d exp mrv=0100 idx2=1 pend=0",
                     mrv, mri[8 +: 4], pend);
        end
        tick();
        tests++;
        if (mrv !== 4'b0000 || mri[8 +: 4] !== 4'd1) begin
            fails++;
            $display("FAIL single_end mrv=%b idx2=%0d exp mrv=0000 idx2=1", mrv, mri[8 +: 4]);
        end
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL single_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_two_lanes();
        logic [3:0] e;
        iv = 1; il = 0; ir = 3; id = 3;
        tick();
        il = 1; ir = 9;
        tick();
        iv = 0;
        for (int k = 2; k <= 8; k++) begin
            e = (k == 5) ? 4'b0001 : (k == 6) ? 4'b0010 : 4'b0000;
            tests++;
            if (mrv !== e) begin
                fails++;
                $display("FAIL two_lanes T+%0d mrv=%b exp=%b", k, mrv, e);
            end
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL two_lanes_model T+%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    // Staggered delays make all three lane-3 tags eligible in the same cycle.
    task automatic test_contention();
        logic       ev;
        logic [3:0] ei;
        iv = 1; il = 3; ir = 5; id = 2; tick();
        ir = 6; id = 1; tick();
        ir = 7; id = 0; tick();
        iv = 0;
        for (int k = 3; k <= 7; k++) begin
            ev = (k >= 4 && k <= 6);
            ei = 4'(k + 1);
            tests++;
            if (mrv[3] !== ev || (ev && mri[12 +: 4] !== ei)) begin
                fails++;
                $display("FAIL contention T+%0d v3=%b idx3=%0d exp v3=%b idx3=%0d",
                         k, mrv[3], mri[12 +: 4], ev, ei);
            end
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL contention_model T+%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        reset = 1; tick(); reset = 0;
        iv = 1; id = 15;
        for (int k = 0; k < 8; k++) begin
            il = 2'(k % 4);
            ir = 4'(k);
            tick();
        end
        tests++;
        if (rdy !== 1'b0 || pend !== 4'd8) begin
            fails++;
            $display("FAIL overflow_full rdy=%b pend=%0d exp rdy=0 pend=8", rdy, pend);
        end
        il = 0; ir = 15;
        tick();
        iv = 0;
        tests++;
        if (ovf !== 1'b1 || pend !== 4'd8 || bad !== 1'b0) begin
            fails++;
            $display("FAIL overflow_drop ovf=%b pend=%0d bad=%b exp ovf=1 pend=8 bad=0", ovf, pend, bad);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL overflow_drain c%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (pend !== 4'd0 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky pend=%0d ovf=%b exp pend=0 ovf=1", pend, ovf);
        end
    endtask

    task automatic test_bad_lane();
        reset = 1; tick(); reset = 0;
        iv = 1; il = 1; ir = 2; id = 15;
        tick();
        tests++;
        if (pend3 !== 4'd1 || bad3 !== 1'b0) begin
            fails++;
            $display("FAIL bad_lane_pre pend3=%0d bad3=%b exp pend3=1 bad3=0", pend3, bad3);
        end
        il = 3; ir = 4;
        tick();
        iv = 0;
        tests++;
        if (pend3 !== 4'd1 || bad3 !== 1'b1 || ovf3 !== 1'b0) begin
            fails++;
            $display("FAIL bad_lane pend3=%0d bad3=%b ovf3=%b exp pend3=1 bad3=1 ovf3=0",
                     pend3, bad3, ovf3);
        end
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL bad_lane_4lane got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        reset = 1; tick(); reset = 0;
        iv = 1; id = 10;
        for (int k = 0; k < 5; k++) begin
            il = 2'($urandom_range(0, 3));
            ir = R'($urandom);
            tick();
        end
        iv = 0;
        reset = 1; tick(); reset = 0;
        tests++;
        if (obs_vec() !== {1'b1, 26'd0}) begin
            fails++;
            $display("FAIL reset_mid got=%h exp=%h", obs_vec(), {1'b1, 26'd0});
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            tests++;
            if (mrv !== 4'b0000 || pend !== 4'd0) begin
                fails++;
                $display("FAIL reset_mid_quiet c%0d mrv=%b pend=%0d exp mrv=0000 pend=0", k, mrv, pend);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            iv    = ($urandom_range(0, 3) != 0);
            il    = 2'($urandom_range(0, 3));
            ir    = R'($urandom);
            id    = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 3))
                                               : DW'($urandom_range(0, 15));
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random c%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            end
        end
        reset = 0;
        iv = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_lanes();
        test_contention();
        test_overflow();
        test_bad_lane();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
